// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Register-file recovery controller: shadows core RF writes, then drives setback/recover and replays the shadow.
// Optional shadow parity checking is enabled by defining CV32E40P_RF_RECOVERY_PARITY_EN.
module cv32e40p_rf_recovery_ctrl #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int SETBACK_CYC = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  recovery_req_i,
    input  logic                  core_we_a_i,
    input  logic [ADDR_WIDTH-1:0] core_waddr_a_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_a_i,
    input  logic                  core_we_b_i,
    input  logic [ADDR_WIDTH-1:0] core_waddr_b_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_b_i,
    output logic                  setback_o,
    output logic                  recover_o,
    output logic                  rf_we_a_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_a_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_a_o,
    output logic                  rf_we_b_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_b_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_b_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    // state   | meaning
    // IDLE    | snooping core RF writes into the shadow, waiting for a request
    // SETBACK | setback and recover asserted, down-counting SETBACK_CYC cycles
    // RESTORE | replaying shadow pairs (2k, 2k+1) into the core RF
    // DONE    | one-cycle completion pulse
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETBACK = 2'd1,
        S_RESTORE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam int KW = (NUM_REGS > 2) ? $clog2(NUM_REGS / 2) : 1;
    localparam int CW = (SETBACK_CYC > 1) ? $clog2(SETBACK_CYC) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(NUM_REGS / 2 - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETBACK_CYC - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [KW-1:0]         r_k;
    logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
    logic [KW:0]           w_idx_a;
    logic [KW:0]           w_idx_b;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic                  w_accept;

    assign w_idx_a  = {r_k, 1'b0};
    assign w_idx_b  = {r_k, 1'b1};
    assign w_rd_a   = r_shadow[w_idx_a];
    assign w_rd_b   = r_shadow[w_idx_b];
    assign w_accept = (r_state == S_IDLE) && recovery_req_i;

    always_comb begin
        w_state_nxt  = r_state;
        setback_o    = 1'b0;
        recover_o    = 1'b0;
        rf_we_a_o    = 1'b0;
        rf_waddr_a_o = '0;
        rf_wdata_a_o = '0;
        rf_we_b_o    = 1'b0;
        rf_waddr_b_o = '0;
        rf_wdata_b_o = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (recovery_req_i) w_state_nxt = S_SETBACK;
            end
            S_SETBACK: begin
                setback_o = 1'b1;
                recover_o = 1'b1;
                busy_o    = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_RESTORE;
            end
            S_RESTORE: begin
                recover_o    = 1'b1;
                busy_o       = 1'b1;
                // x0 is hardwired in the core, never write it back
                rf_we_a_o    = (r_k != '0);
                rf_waddr_a_o = ADDR_WIDTH'(w_idx_a);
                rf_wdata_a_o = w_rd_a;
                rf_we_b_o    = 1'b1;
                rf_waddr_b_o = ADDR_WIDTH'(w_idx_b);
                rf_wdata_b_o = w_rd_b;
                if (r_k == K_LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                busy_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= CNT_LOAD;
                    r_k   <= '0;
                end
                S_SETBACK: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                S_RESTORE: r_k <= r_k + KW'(1);
                default: ;
            endcase
        end
    end

    // Snooping only in IDLE keeps the restore traffic out of the shadow; B wins on a same-address collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
        end else if (r_state == S_IDLE) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (core_we_b_i && (core_waddr_b_i == ADDR_WIDTH'(i)))
                    r_shadow[i] <= core_wdata_b_i;
                else if (core_we_a_i && (core_waddr_a_i == ADDR_WIDTH'(i)))
                    r_shadow[i] <= core_wdata_a_i;
            end
        end
    end

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
    logic r_par [NUM_REGS];
    logic r_err;
    logic w_perr;

    assign w_perr = (r_state == S_RESTORE) &&
                    (((^w_rd_a) ^ r_par[w_idx_a]) || ((^w_rd_b) ^ r_par[w_idx_b]));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) r_par[i] <= 1'b0;
        end else if (r_state == S_IDLE) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (core_we_b_i && (core_waddr_b_i == ADDR_WIDTH'(i)))
                    r_par[i] <= ^core_wdata_b_i;
                else if (core_we_a_i && (core_waddr_a_i == ADDR_WIDTH'(i)))
                    r_par[i] <= ^core_wdata_a_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)         r_err <= 1'b0;
        else if (w_accept) r_err <= 1'b0;
        else if (w_perr)   r_err <= 1'b1;
    end

    // The live term lets the error show on the very restore cycle that reads the bad entry.
    assign err_o = r_err || w_perr;
`else
    logic w_unused;
    assign w_unused = w_accept;
    assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// Directed bench for cv32e40p_rf_recovery_ctrl: capture vector table, full restore sequences, reset abort.
module tb_cv32e40p_rf_recovery_ctrl;
    localparam int NR = 32;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int SB = 2;
    localparam int NK = NR / 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          recovery_req_i = 1'b0;
    logic          core_we_a_i = 1'b0;
    logic [AW-1:0] core_waddr_a_i = '0;
    logic [DW-1:0] core_wdata_a_i = '0;
    logic          core_we_b_i = 1'b0;
    logic [AW-1:0] core_waddr_b_i = '0;
    logic [DW-1:0] core_wdata_b_i = '0;
    logic          setback_o, recover_o, rf_we_a_o, rf_we_b_o, busy_o, done_o, err_o;
    logic [AW-1:0] rf_waddr_a_o, rf_waddr_b_o;
    logic [DW-1:0] rf_wdata_a_o, rf_wdata_b_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_sh [NR];
    logic [DW-1:0] got_sh [NR];

    typedef struct {
        bit          we_a;
        logic [AW-1:0] a_a;
        logic [DW-1:0] d_a;
        bit          we_b;
        logic [AW-1:0] a_b;
        logic [DW-1:0] d_b;
        int          ca;
        logic [DW-1:0] ea;
        int          cb;
        logic [DW-1:0] eb;
    } vec_t;
    vec_t vecs [9];

    cv32e40p_rf_recovery_ctrl #(
        .NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETBACK_CYC(SB)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .recovery_req_i(recovery_req_i),
        .core_we_a_i(core_we_a_i), .core_waddr_a_i(core_waddr_a_i), .core_wdata_a_i(core_wdata_a_i),
        .core_we_b_i(core_we_b_i), .core_waddr_b_i(core_waddr_b_i), .core_wdata_b_i(core_wdata_b_i),
        .setback_o(setback_o), .recover_o(recover_o),
        .rf_we_a_o(rf_we_a_o), .rf_waddr_a_o(rf_waddr_a_o), .rf_wdata_a_o(rf_wdata_a_o),
        .rf_we_b_o(rf_we_b_o), .rf_waddr_b_o(rf_waddr_b_o), .rf_wdata_b_o(rf_wdata_b_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " setback"}, 64'(setback_o), 64'd0);
        chk({tag, " recover"}, 64'(recover_o), 64'd0);
        chk({tag, " busy"}, 64'(busy_o), 64'd0);
        chk({tag, " done"}, 64'(done_o), 64'd0);
        chk({tag, " we_a"}, 64'(rf_we_a_o), 64'd0);
        chk({tag, " we_b"}, 64'(rf_we_b_o), 64'd0);
        chk({tag, " waddr_b"}, 64'(rf_waddr_b_o), 64'd0);
        chk({tag, " wdata_a"}, 64'(rf_wdata_a_o), 64'd0);
    endtask

    // Runs one recovery against exp_sh; err_k < 0 means no parity error expected.
    task automatic do_recovery(input bit hold, input int inj_k, input int err_k, input string tag);
        int k;
        bit eexp;
        recovery_req_i = 1'b1;
        for (int e = 1; e <= SB + NK + 1; e++) begin
            @(posedge clk_i); #1;
            if (!hold) recovery_req_i = 1'b0;
            core_we_a_i = 1'b0;
            k = e - SB - 1;
            eexp = (err_k >= 0) && (k >= err_k);
            chk($sformatf("%s e=%0d err", tag, e), 64'(err_o), 64'(eexp));
            if (e <= SB) begin
                chk($sformatf("%s sb e=%0d setback", tag, e), 64'(setback_o), 64'd1);
                chk($sformatf("%s sb e=%0d recover", tag, e), 64'(recover_o), 64'd1);
                chk($sformatf("%s sb e=%0d busy", tag, e), 64'(busy_o), 64'd1);
                chk($sformatf("%s sb e=%0d we", tag, e), 64'({rf_we_a_o, rf_we_b_o}), 64'd0);
                chk($sformatf("%s sb e=%0d wdata_b", tag, e), 64'(rf_wdata_b_o), 64'd0);
            end else if (e <= SB + NK) begin
                chk($sformatf("%s k=%0d setback", tag, k), 64'(setback_o), 64'd0);
                chk($sformatf("%s k=%0d recover", tag, k), 64'(recover_o), 64'd1);
                chk($sformatf("%s k=%0d done", tag, k), 64'(done_o), 64'd0);
                chk($sformatf("%s k=%0d we_a", tag, k), 64'(rf_we_a_o), 64'(k != 0));
                chk($sformatf("%s k=%0d we_b", tag, k), 64'(rf_we_b_o), 64'd1);
                chk($sformatf("%s k=%0d waddr_a", tag, k), 64'(rf_waddr_a_o), 64'(2 * k));
                chk($sformatf("%s k=%0d waddr_b", tag, k), 64'(rf_waddr_b_o), 64'(2 * k + 1));
                chk($sformatf("%s k=%0d wdata_a", tag, k), 64'(rf_wdata_a_o), 64'(exp_sh[2 * k]));
                chk($sformatf("%s k=%0d wdata_b", tag, k), 64'(rf_wdata_b_o), 64'(exp_sh[2 * k + 1]));
                got_sh[2 * k]     = rf_wdata_a_o;
                got_sh[2 * k + 1] = rf_wdata_b_o;
                if (k == inj_k) begin
                    core_we_a_i    = 1'b1;
                    core_waddr_a_i = 6'd9;
                    core_wdata_a_i = 32'h0000_00AA;
                end
            end else begin
                chk($sformatf("%s done pulse", tag), 64'(done_o), 64'd1);
                chk($sformatf("%s done recover", tag), 64'(recover_o), 64'd0);
                chk($sformatf("%s done setback", tag), 64'(setback_o), 64'd0);
                chk($sformatf("%s done busy", tag), 64'(busy_o), 64'd1);
                chk($sformatf("%s done we", tag), 64'({rf_we_a_o, rf_we_b_o}), 64'd0);
            end
        end
        recovery_req_i = 1'b0;
        @(posedge clk_i); #1;
        chk({tag, " idle busy"}, 64'(busy_o), 64'd0);
        chk({tag, " idle done"}, 64'(done_o), 64'd0);
        chk({tag, " idle err"}, 64'(err_o), 64'(err_k >= 0));
    endtask

    initial begin
        vecs[0] = '{1'b1, 6'd5,  32'hDEADBEEF, 1'b1, 6'd6,  32'h12345678, 5,  32'hDEADBEEF, 6,  32'h12345678};
        vecs[1] = '{1'b1, 6'd7,  32'h00000001, 1'b1, 6'd7,  32'h00000002, 7,  32'h00000002, 7,  32'h00000002};
        vecs[2] = '{1'b1, 6'd0,  32'hFFFFFFFF, 1'b1, 6'd1,  32'h00000011, 0,  32'h00000000, 1,  32'h00000011};
        vecs[3] = '{1'b1, 6'd30, 32'h0BADF00D, 1'b1, 6'd31, 32'hCAFEF00D, 30, 32'h0BADF00D, 31, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 6'd9,  32'h00000055, 1'b0, 6'd8,  32'h00000077, 9,  32'h00000055, 8,  32'h00000000};
        vecs[5] = '{1'b1, 6'd2,  32'h00001111, 1'b0, 6'd3,  32'h0000FFFF, 2,  32'h00002222, 3,  32'h00003333};
        vecs[6] = '{1'b1, 6'd2,  32'h00002222, 1'b1, 6'd3,  32'h00003333, 2,  32'h00002222, 3,  32'h00003333};
        vecs[7] = '{1'b1, 6'd33, 32'h00000BAD, 1'b1, 6'd46, 32'h0000BAD2, 1,  32'h00000011, 14, 32'h00000000};
        vecs[8] = '{1'b0, 6'd4,  32'h44444444, 1'b0, 6'd10, 32'hAAAA5555, 4,  32'h00000000, 10, 32'h00000000};

        // reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk_quiet("reset");
        chk("reset err", 64'(err_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk_quiet("post-reset idle");

        // recovery from a freshly reset shadow restores zeros
        for (int i = 0; i < NR; i++) exp_sh[i] = '0;
        do_recovery(1'b0, -1, -1, "zeros");

        // capture vector table, applied one per cycle in IDLE
        for (int v = 0; v < 9; v++) begin
            core_we_a_i    = vecs[v].we_a;
            core_waddr_a_i = vecs[v].a_a;
            core_wdata_a_i = vecs[v].d_a;
            core_we_b_i    = vecs[v].we_b;
            core_waddr_b_i = vecs[v].a_b;
            core_wdata_b_i = vecs[v].d_b;
            @(posedge clk_i); #1;
        end
        core_we_a_i = 1'b0;
        core_we_b_i = 1'b0;
        for (int i = 0; i < NR; i++) exp_sh[i] = '0;
        for (int v = 0; v < 9; v++) begin
            exp_sh[vecs[v].ca] = vecs[v].ea;
            exp_sh[vecs[v].cb] = vecs[v].eb;
        end

        // request held high throughout; x9 written by the core during restore must not be captured
        do_recovery(1'b1, 0, -1, "table");
        for (int v = 0; v < 9; v++) begin
            chk($sformatf("vec%0d restored x%0d", v, vecs[v].ca), 64'(got_sh[vecs[v].ca]), 64'(vecs[v].ea));
            chk($sformatf("vec%0d restored x%0d", v, vecs[v].cb), 64'(got_sh[vecs[v].cb]), 64'(vecs[v].eb));
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            chk($sformatf("single recovery idle c=%0d busy", c), 64'(busy_o), 64'd0);
            chk($sformatf("single recovery idle c=%0d setback", c), 64'(setback_o), 64'd0);
        end

        // reset in the middle of RESTORE (k=5)
        recovery_req_i = 1'b1;
        @(posedge clk_i); #1;
        recovery_req_i = 1'b0;
        for (int e = 2; e <= SB + 1 + 5; e++) begin
            @(posedge clk_i); #1;
        end
        chk("abort pre k=5 waddr_b", 64'(rf_waddr_b_o), 64'd11);
        chk("abort pre k=5 wdata_b", 64'(rf_wdata_b_o), 64'h0000_0000);
        chk("abort pre k=5 wdata_a", 64'(rf_wdata_a_o), 64'h0000_0000);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk_quiet("abort");
        chk("abort err", 64'(err_o), 64'd0);
        rst_i = 1'b0;
        for (int i = 0; i < NR; i++) exp_sh[i] = '0;
        do_recovery(1'b0, -1, -1, "after-abort");

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
        // corrupt shadow[3] bit 0 behind the parity bit's back
        dut.r_shadow[3][0] = 1'b1;
        exp_sh[3] = 32'h0000_0001;
        do_recovery(1'b0, -1, 1, "parity");
        do_recovery(1'b0, -1, 1, "parity-again");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
